pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter PIPE_DEPTH, default 3, meaning max in-flight register writes per rd (issue to writeback).
REQ-002 SHALL have parameter FLUSH_CYCLES, default 1, meaning bubble cycles injected after a redirect.
REQ-003 SHALL have one clock and an asynchronous, active-high reset: i_CLK (input, 1, rising-edge clock) and i_RST (input, 1, async active-high reset).
REQ-004 i_INSTRUCTION_VALID  in  1  fetch presents an instruction to decode.
REQ-005 i_RS1_PTR / i_RS2_PTR  in  5 each  source register indices.
REQ-006 i_RS1_USED / i_RS2_USED  in  1 each  source actually read.
REQ-007 i_RD_PTR  in  5; i_REG_WE  in  1; i_IS_LOAD  in  1  destination, write intent, load flag of the decoding instruction.
REQ-008 i_WB_VALID  in  1; i_WB_RD_PTR  in  5  writeback retires a write to rd.
REQ-009 i_MEM_BUSY  in  1  data memory not ready; i_REDIRECT  in  1  taken branch/jump/trap/mret PC change.
REQ-010 o_DECODE_EN  out  1; o_EXECUTE_EN  out  1; o_BUBBLE  out  1; o_FLUSH  out  1.
REQ-011 o_STATE  out  2  FSM state; o_STALL_CNT  out  32  stall-cycle performance counter.

Function
REQ-012 FSM states: RUN=0, STALL=1, MEMWAIT=2, FLUSH=3; priority in every state: redirect > mem_busy > hazard.
REQ-013 RUN/STALL: i_REDIRECT -> FLUSH; else i_MEM_BUSY -> MEMWAIT; else hazard -> STALL; else RUN.
REQ-014 MEMWAIT: leave when i_MEM_BUSY=0, to FLUSH if a redirect was latched during the wait, else RUN; a redirect seen in MEMWAIT SHALL be latched (not dropped).
REQ-015 FLUSH: hold exactly FLUSH_CYCLES cycles via a down-counter, then RUN; a new redirect in FLUSH reloads the counter.
REQ-016 issue = i_INSTRUCTION_VALID & o_DECODE_EN.
REQ-017 o_DECODE_EN (combinational) = state in {RUN,STALL} & ~hazard & ~i_MEM_BUSY & ~i_REDIRECT.
REQ-018 o_EXECUTE_EN = ~i_MEM_BUSY & state!=MEMWAIT.
REQ-019 o_BUBBLE = o_EXECUTE_EN & ~issue; o_FLUSH = (state==FLUSH) | i_REDIRECT.
REQ-020 Scoreboard: one saturating counter per register 1..31, width ceil(log2(PIPE_DEPTH+1)); +1 on issue with i_REG_WE, -1 on i_WB_VALID; simultaneous inc/dec of the same rd leaves it unchanged.
REQ-021 x0 SHALL never be tracked and never cause a hazard.
REQ-022 On a redirect, the counters SHALL NOT be cleared; already-issued instructions still write back.
REQ-023 hazard = i_INSTRUCTION_VALID & a used source matches per the configuration rule (REQ-027/028).
REQ-024 o_STALL_CNT increments on every cycle with i_INSTRUCTION_VALID & ~o_DECODE_EN and saturates at 2^32-1.
REQ-025 Counter underflow (writeback with counter 0) SHALL hold at 0 and is a verification error.

Reset
REQ-026 On i_RST: state RUN, all scoreboard counters 0, latched redirect 0, flush counter 0, o_STALL_CNT 0, last-load tracking cleared; outputs follow combinationally from these, and reset asserted mid-stall SHALL drop the stall on the same edge.

Configuration
REQ-027 With FORWARDING_EN defined: hazard is load-use only; it is asserted when the previously issued instruction was a load (registered rd plus flag, cleared by a non-load issue or by a bubble) whose rd matches a used source, giving one bubble.
REQ-028 Without FORWARDING_EN: hazard is asserted while the scoreboard counter of any used source is nonzero, so decode stalls until writeback.

Structure
REQ-029 Package pipe_ctrl_pkg SHALL hold the state encoding constants and the PIPE_DEPTH/FLUSH_CYCLES defaults.
REQ-030 The scoreboard SHALL be a sub-module named pipe_scoreboard, which takes the issue/writeback ports and provides per-source busy outputs.

Verification
REQ-031 Scenario: without FORWARDING_EN, issue `add x5` followed by `sub x6,x5,x1`, with writeback x5 three cycles later -> o_DECODE_EN=0 for 3 cycles, o_BUBBLE=1, o_STALL_CNT=3.
REQ-032 Scenario: with FORWARDING_EN, issue `lw x7` followed by `add x8,x7,x2` -> exactly 1 stall cycle; an `add x9` after an ALU op on x9 -> 0 stalls.
REQ-033 Scenario: i_MEM_BUSY held 4 cycles, with i_REDIRECT pulsed in the 2nd of them -> MEMWAIT for 4 cycles, o_EXECUTE_EN=0, then FLUSH for FLUSH_CYCLES, then RUN.
REQ-034 Scenario: in the same cycle, issue writing x10 and writeback of x10 with counter 1 -> counter stays 1.
REQ-035 Scenario: instruction using x0 with x0 as rd -> no stall; the scoreboard is unchanged.
REQ-036 Scenario: i_RST asserted asynchronously during STALL with a nonzero counter -> state=0, o_STALL_CNT=0, and o_DECODE_EN=1 for the next valid instruction.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller:
// state encoding, default depths and a counter-width helper.
package pipe_ctrl_pkg;

  localparam int DEF_PIPE_DEPTH   = 3;
  localparam int DEF_FLUSH_CYCLES = 1;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_STALL   = 2'd1,
    ST_MEMWAIT = 2'd2,
    ST_FLUSH   = 2'd3
  } state_t;

  // Bits needed to hold 0..max inclusive (never less than one bit).
  function automatic int cnt_width(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/pipe_scoreboard.sv
// Per-register in-flight write tracker for x1..x31. Each register has a
// saturating counter bumped on an issued write and dropped on writeback;
// x0 is never tracked. A writeback against an empty counter holds at zero.
module pipe_scoreboard
  import pipe_ctrl_pkg::*;
#(
  parameter int PIPE_DEPTH = DEF_PIPE_DEPTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       issue_we,
  input  logic [4:0] rd,
  input  logic       wb_valid,
  input  logic [4:0] wb_rd,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  output logic       rs1_busy,
  output logic       rs2_busy
);

  localparam int CW = cnt_width(PIPE_DEPTH);
  localparam logic [CW-1:0] CMAX = CW'(PIPE_DEPTH);

  logic [CW-1:0] cnt [32];
  logic [31:0]   inc_vec;
  logic [31:0]   dec_vec;

  // One-hot increment/decrement requests; x0 requests are dropped here.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (issue_we && (rd != 5'd0)) inc_vec[rd] = 1'b1;
    if (wb_valid && (wb_rd != 5'd0)) dec_vec[wb_rd] = 1'b1;
  end

  // Counter update; a same-cycle inc and dec of one register cancel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < 32; r++) begin
        if (inc_vec[r] && !dec_vec[r] && (cnt[r] != CMAX))
          cnt[r] <= cnt[r] + 1'b1;
        else if (dec_vec[r] && !inc_vec[r] && (cnt[r] != '0))
          cnt[r] <= cnt[r] - 1'b1;
      end
    end
  end

  // Busy lookup comes only from registered counts, so no loop through issue.
  always_comb begin
    rs1_busy = (rs1 != 5'd0) && (cnt[rs1] != '0);
    rs2_busy = (rs2 != 5'd0) && (cnt[rs2] != '0);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control FSM: decode/execute enables, bubble and flush signals,
// hazard detection and a saturating stall-cycle counter.
// Build option: define FORWARDING_EN for load-use-only hazards; otherwise
// decode waits for writeback of every in-flight source register.
//
// state   | meaning
// RUN     | normal flow
// STALL   | decode held by a data hazard
// MEMWAIT | data memory busy, execute frozen; redirects are remembered
// FLUSH   | redirect taken, bubbles injected for FLUSH_CYCLES cycles
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int PIPE_DEPTH   = DEF_PIPE_DEPTH,
  parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
  input  logic        i_CLK,
  input  logic        i_RST,
  input  logic        i_INSTRUCTION_VALID,
  input  logic [4:0]  i_RS1_PTR,
  input  logic [4:0]  i_RS2_PTR,
  input  logic        i_RS1_USED,
  input  logic        i_RS2_USED,
  input  logic [4:0]  i_RD_PTR,
  input  logic        i_REG_WE,
  input  logic        i_IS_LOAD,
  input  logic        i_WB_VALID,
  input  logic [4:0]  i_WB_RD_PTR,
  input  logic        i_MEM_BUSY,
  input  logic        i_REDIRECT,
  output logic        o_DECODE_EN,
  output logic        o_EXECUTE_EN,
  output logic        o_BUBBLE,
  output logic        o_FLUSH,
  output logic [1:0]  o_STATE,
  output logic [31:0] o_STALL_CNT
);

  localparam int FW = cnt_width(FLUSH_CYCLES);
  localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYCLES);

  state_t        state, state_nxt;
  logic          redir_lat, redir_lat_nxt;
  logic [FW-1:0] flush_cnt, flush_cnt_nxt;
  logic [31:0]   stall_cnt;
  logic          hazard, issue, decode_en, execute_en, bubble;
  logic          rs1_busy, rs2_busy;

  pipe_scoreboard #(.PIPE_DEPTH(PIPE_DEPTH)) u_sb (
    .clk      (i_CLK),
    .rst      (i_RST),
    .issue_we (issue & i_REG_WE),
    .rd       (i_RD_PTR),
    .wb_valid (i_WB_VALID),
    .wb_rd    (i_WB_RD_PTR),
    .rs1      (i_RS1_PTR),
    .rs2      (i_RS2_PTR),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy)
  );

`ifdef FORWARDING_EN
  logic       ld_valid;
  logic [4:0] ld_rd;
  logic       unused_busy;

  assign unused_busy = rs1_busy ^ rs2_busy;

  // Load-use only: everything else is covered by forwarding paths.
  always_comb begin
    hazard = i_INSTRUCTION_VALID && ld_valid && (ld_rd != 5'd0) &&
             ((i_RS1_USED && (i_RS1_PTR == ld_rd)) ||
              (i_RS2_USED && (i_RS2_PTR == ld_rd)));
  end

  // Remember whether the last issued instruction was a load; a bubble means
  // the load has moved on far enough to forward from.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      ld_valid <= 1'b0;
      ld_rd    <= 5'd0;
    end else if (issue) begin
      ld_valid <= i_IS_LOAD & i_REG_WE;
      ld_rd    <= i_RD_PTR;
    end else if (bubble) begin
      ld_valid <= 1'b0;
    end
  end
`else
  logic unused_load;

  assign unused_load = i_IS_LOAD;

  // Without forwarding any source with a pending write blocks decode.
  always_comb begin
    hazard = i_INSTRUCTION_VALID &&
             ((i_RS1_USED && rs1_busy) || (i_RS2_USED && rs2_busy));
  end
`endif

  // State, redirect latch and flush counter registers.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state     <= ST_RUN;
      redir_lat <= 1'b0;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      redir_lat <= redir_lat_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  // Next-state and output decode; redirect beats mem_busy beats hazard.
  always_comb begin
    state_nxt     = state;
    redir_lat_nxt = redir_lat;
    flush_cnt_nxt = flush_cnt;
    unique case (state)
      ST_RUN, ST_STALL: begin
        if (i_REDIRECT) begin
          state_nxt     = ST_FLUSH;
          flush_cnt_nxt = FLUSH_LOAD;
        end else if (i_MEM_BUSY) begin
          state_nxt = ST_MEMWAIT;
        end else if (hazard) begin
          state_nxt = ST_STALL;
        end else begin
          state_nxt = ST_RUN;
        end
      end
      ST_MEMWAIT: begin
        if (!i_MEM_BUSY) begin
          redir_lat_nxt = 1'b0;
          if (redir_lat || i_REDIRECT) begin
            state_nxt     = ST_FLUSH;
            flush_cnt_nxt = FLUSH_LOAD;
          end else begin
            state_nxt = ST_RUN;
          end
        end else if (i_REDIRECT) begin
          redir_lat_nxt = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (i_REDIRECT) begin
          flush_cnt_nxt = FLUSH_LOAD;
        end else if (flush_cnt <= FW'(1)) begin
          state_nxt     = ST_RUN;
          flush_cnt_nxt = '0;
        end else begin
          flush_cnt_nxt = flush_cnt - 1'b1;
        end
      end
      default: state_nxt = ST_RUN;
    endcase

    decode_en  = ((state == ST_RUN) || (state == ST_STALL)) &&
                 !hazard && !i_MEM_BUSY && !i_REDIRECT;
    execute_en = !i_MEM_BUSY && (state != ST_MEMWAIT);
    issue      = i_INSTRUCTION_VALID && decode_en;
    bubble     = execute_en && !issue;
  end

  // Stall-cycle performance counter, saturating at all-ones.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST)
      stall_cnt <= '0;
    else if (i_INSTRUCTION_VALID && !decode_en && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 32'd1;
  end

  assign o_DECODE_EN  = decode_en;
  assign o_EXECUTE_EN = execute_en;
  assign o_BUBBLE     = bubble;
  assign o_FLUSH      = (state == ST_FLUSH) || i_REDIRECT;
  assign o_STATE      = state;
  assign o_STALL_CNT  = stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model of the pipeline rules.
module tb_pipe_ctrl;

  localparam int DEPTH = 3;
  localparam int FCYC  = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic valid = 1'b0, u1 = 1'b0, u2 = 1'b0, we = 1'b0, ld = 1'b0;
  logic wbv = 1'b0, mb = 1'b0, rdr = 1'b0;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0, wb_rd = '0;
  logic dec_en, exe_en, bubble, flush;
  logic [1:0] state;
  logic [31:0] stall_cnt;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  pipe_ctrl #(.PIPE_DEPTH(DEPTH), .FLUSH_CYCLES(FCYC)) dut (
    .i_CLK(clk), .i_RST(rst), .i_INSTRUCTION_VALID(valid),
    .i_RS1_PTR(rs1), .i_RS2_PTR(rs2), .i_RS1_USED(u1), .i_RS2_USED(u2),
    .i_RD_PTR(rd), .i_REG_WE(we), .i_IS_LOAD(ld),
    .i_WB_VALID(wbv), .i_WB_RD_PTR(wb_rd),
    .i_MEM_BUSY(mb), .i_REDIRECT(rdr),
    .o_DECODE_EN(dec_en), .o_EXECUTE_EN(exe_en), .o_BUBBLE(bubble),
    .o_FLUSH(flush), .o_STATE(state), .o_STALL_CNT(stall_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int     m_state;          // 0 run, 1 stall, 2 memwait, 3 flush
  int     m_cnt [32];       // pending writes per register
  bit     m_lat;            // redirect remembered during memwait
  int     m_flush;          // flush cycles still to go
  longint m_stalls;
  bit     m_ld;             // last issued instruction was a load
  int     m_ld_rd;

  function automatic bit m_hazard();
    if (!valid) return 1'b0;
`ifdef FORWARDING_EN
    return m_ld && (m_ld_rd != 0) &&
           ((u1 && int'(rs1) == m_ld_rd) || (u2 && int'(rs2) == m_ld_rd));
`else
    return (u1 && rs1 != 0 && m_cnt[rs1] > 0) ||
           (u2 && rs2 != 0 && m_cnt[rs2] > 0);
`endif
  endfunction

  function automatic bit m_dec_en();
    return (m_state <= 1) && !m_hazard() && !mb && !rdr;
  endfunction
  function automatic bit m_exe_en();
    return !mb && m_state != 2;
  endfunction
  function automatic bit m_issue();
    return valid && m_dec_en();
  endfunction
  function automatic bit m_bubble();
    return m_exe_en() && !m_issue();
  endfunction
  function automatic bit m_flush_o();
    return m_state == 3 || rdr;
  endfunction

  task automatic model_reset();
    m_state = 0; m_lat = 0; m_flush = 0; m_stalls = 0; m_ld = 0; m_ld_rd = 0;
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
  endtask

  task automatic model_step();
    bit iss, bub, haz, den;
    bit inc, dec;
    iss = m_issue(); bub = m_bubble(); haz = m_hazard(); den = m_dec_en();
    inc = iss && we && rd != 0;
    dec = wbv && wb_rd != 0;
    if (inc && dec && rd == wb_rd) begin
      // pending count unchanged
    end else begin
      if (inc) m_cnt[rd] = (m_cnt[rd] + 1 > DEPTH) ? DEPTH : m_cnt[rd] + 1;
      if (dec && m_cnt[wb_rd] > 0) m_cnt[wb_rd] = m_cnt[wb_rd] - 1;
    end
    if (valid && !den && m_stalls < 64'hFFFF_FFFF) m_stalls++;
    if (iss) begin
      m_ld = ld && we; m_ld_rd = int'(rd);
    end else if (bub) begin
      m_ld = 0;
    end
    if (m_state <= 1) begin
      if (rdr) begin m_state = 3; m_flush = FCYC; end
      else if (mb) m_state = 2;
      else m_state = haz ? 1 : 0;
    end else if (m_state == 2) begin
      if (!mb) begin
        if (m_lat || rdr) begin m_state = 3; m_flush = FCYC; end
        else m_state = 0;
        m_lat = 0;
      end else if (rdr) m_lat = 1;
    end else begin
      if (rdr) m_flush = FCYC;
      else begin
        m_flush--;
        if (m_flush <= 0) begin m_state = 0; m_flush = 0; end
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else model_step();
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      check("model_state",  state,     m_state);
      check("model_dec_en", dec_en,    m_dec_en());
      check("model_exe_en", exe_en,    m_exe_en());
      check("model_bubble", bubble,    m_bubble());
      check("model_flush",  flush,     m_flush_o());
      check("model_stalls", stall_cnt, m_stalls);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_in(input bit v, input logic [4:0] a, input bit ua,
                        input logic [4:0] b, input bit ub, input logic [4:0] d,
                        input bit w, input bit l, input bit wv,
                        input logic [4:0] wr, input bit m, input bit r);
    valid = v; rs1 = a; u1 = ua; rs2 = b; u2 = ub; rd = d; we = w; ld = l;
    wbv = wv; wb_rd = wr; mb = m; rdr = r;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  int mb_left;
  int cand[$];

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cmp_en = 1'b1;
    adv();

    // reset state with an independent instruction presented
    set_in(1, 3, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("rst_state", state, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_dec_en", dec_en, 1);
    check("rst_exe_en", exe_en, 1);
    check("rst_flush", flush, 0);
    adv();

`ifdef FORWARDING_EN
    // lw x7 ; add x8,x7,x2 -> one stall
    set_in(1, 1, 1, 0, 0, 7, 1, 1, 0, 0, 0, 0);
    @(negedge clk); check("lu_load_dec", dec_en, 1); adv();
    set_in(1, 7, 1, 2, 1, 8, 1, 0, 0, 0, 0, 0);
    @(negedge clk); check("lu_stall_dec", dec_en, 0); check("lu_bubble", bubble, 1); adv();
    @(negedge clk); check("lu_resume_dec", dec_en, 1); check("lu_stall_cnt", stall_cnt, 1); adv();
    // add x9 ; add x10,x9 -> no stall
    set_in(1, 1, 1, 2, 1, 9, 1, 0, 0, 0, 0, 0);
    @(negedge clk); check("alu_dec0", dec_en, 1); adv();
    set_in(1, 9, 1, 9, 1, 10, 1, 0, 0, 0, 0, 0);
    @(negedge clk); check("alu_dec1", dec_en, 1); adv();
    idle(); adv();
`else
    // add x5,x1,x2 ; sub x6,x5,x1 with writeback of x5 three cycles later
    set_in(1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 0, 0);
    @(negedge clk); check("raw_add_dec", dec_en, 1); adv();
    for (int k = 0; k < 3; k++) begin
      set_in(1, 5, 1, 1, 1, 6, 1, 0, k == 2, 5, 0, 0);
      @(negedge clk);
      check("raw_stall_dec", dec_en, 0);
      check("raw_stall_bubble", bubble, 1);
      adv();
    end
    set_in(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("raw_resume_dec", dec_en, 1);
    check("raw_stall_cnt", stall_cnt, 3);
    adv();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 0); adv();

    // same-cycle issue and writeback of x10 keeps the count at 1
    set_in(1, 0, 0, 0, 0, 10, 1, 0, 0, 0, 0, 0); adv();
    set_in(1, 0, 0, 0, 0, 10, 1, 0, 1, 10, 0, 0);
    @(negedge clk); check("sim_incdec_dec", dec_en, 1); adv();
    set_in(1, 10, 1, 0, 0, 0, 0, 0, 1, 10, 0, 0);
    @(negedge clk); check("sim_one_left", dec_en, 0); adv();
    set_in(1, 10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); check("sim_drained", dec_en, 1); adv();
`endif

    // x0 as source and destination never stalls
    set_in(1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    @(negedge clk); check("x0_write_dec", dec_en, 1); adv();
    set_in(1, 0, 1, 0, 1, 11, 1, 0, 0, 0, 0, 0);
    @(negedge clk); check("x0_read_dec", dec_en, 1); adv();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 11, 0, 0); adv();

    // mem busy 4 cycles, redirect in the 2nd
    for (int k = 0; k < 4; k++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, k == 1);
      @(negedge clk);
      check("mw_state", state, (k == 0) ? 0 : 2);
      check("mw_exe_en", exe_en, 0);
      adv();
    end
    idle();
    @(negedge clk); check("mw_last_state", state, 2); check("mw_last_exe", exe_en, 0); adv();
    @(negedge clk); check("mw_flush_state", state, 3); check("mw_flush_out", flush, 1); adv();
    @(negedge clk); check("mw_run_state", state, 0); check("mw_run_flush", flush, 0); adv();

`ifndef FORWARDING_EN
    // async reset in STALL with a pending write
    set_in(1, 0, 0, 0, 0, 12, 1, 0, 0, 0, 0, 0); adv();
    set_in(1, 12, 1, 0, 0, 13, 1, 0, 0, 0, 0, 0);
    @(negedge clk); check("ar_hazard_dec", dec_en, 0); adv();
    @(negedge clk); check("ar_stall_state", state, 1);
    #2 rst = 1'b1;
    #1;
    check("ar_state", state, 0);
    check("ar_stall_cnt", stall_cnt, 0);
    check("ar_dec_en", dec_en, 1);
    @(negedge clk); rst = 1'b0;
    adv();
`endif

    // randomized traffic
    mb_left = 0;
    for (int c = 0; c < 4000; c++) begin
      valid = ($urandom % 10) < 7;
      rs1 = 5'($urandom % 8); rs2 = 5'($urandom % 8); rd = 5'($urandom % 8);
      u1 = $urandom % 4 != 0; u2 = $urandom % 2 == 0;
      we = ($urandom % 10) < 7; ld = ($urandom % 10) < 3;
      if (mb_left > 0) begin mb = 1; mb_left--; end
      else if ($urandom % 12 == 0) begin mb = 1; mb_left = $urandom_range(4, 0); end
      else mb = 0;
      rdr = ($urandom % 15) == 0;
      cand.delete();
      for (int r = 1; r < 32; r++) if (m_cnt[r] > 0) cand.push_back(r);
      if (cand.size() > 0 && $urandom % 2 == 0) begin
        wbv = 1; wb_rd = 5'(cand[$urandom % cand.size()]);
      end else begin
        wbv = 0; wb_rd = 5'($urandom % 32);
      end
      adv();
    end
    idle();
    adv();
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
